// File: rtl/piso_serializer_if.sv
// Parallel-in / serial-out handshake and serial stream bundle.
interface piso_serializer_if #(
   parameter int unsigned WIDTH = 4
);
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic             serial_out;
   logic             serial_valid;
   logic             frame_start;
   logic             frame_end;
   logic             busy;

   // Upstream producer / stream observer side.
   modport master (
      output in_valid,
      output in_data,
      input  in_ready,
      input  serial_out,
      input  serial_valid,
      input  frame_start,
      input  frame_end,
      input  busy
   );

   // Serializer side.
   modport slave (
      input  in_valid,
      input  in_data,
      output in_ready,
      output serial_out,
      output serial_valid,
      output frame_start,
      output frame_end,
      output busy
   );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer with a one-entry holding register,
// optional inter-word gap and first/last-bit framing flags.
module piso_serializer #(
   parameter int unsigned WIDTH     = 4,
   parameter int unsigned MSB_FIRST = 1,
   parameter int unsigned GAP       = 0
) (
   input  logic             clock,
   input  logic             reset,
   piso_serializer_if.slave bus
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);
   localparam int unsigned GAP_W = 4;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
   localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'(GAP - 1);

   // Reject illegal parameterisations at elaboration.
   if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
      $error("piso_serializer: WIDTH must be in 2..16");
   end
   if (GAP > 15) begin : g_bad_gap
      $error("piso_serializer: GAP must be in 0..15");
   end

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] hold_q, hold_d;
   logic             hold_full_q, hold_full_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [GAP_W-1:0] gap_q, gap_d;

   logic in_ready_q, in_ready_d;
   logic serial_out_q, serial_out_d;
   logic serial_valid_q, serial_valid_d;
   logic frame_start_q, frame_start_d;
   logic frame_end_q, frame_end_d;
   logic busy_q, busy_d;

   logic accept_c;
   logic load_c;

   // Advance the shift register by one bit in the configured direction.
   function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] v);
      if (MSB_FIRST != 0) begin
         return {v[WIDTH-2:0], 1'b0};
      end
      return {1'b0, v[WIDTH-1:1]};
   endfunction

   // Bit that leaves the shift register first.
   function automatic logic head_bit(input logic [WIDTH-1:0] v);
      if (MSB_FIRST != 0) begin
         return v[WIDTH-1];
      end
      return v[0];
   endfunction

   assign accept_c = bus.in_valid & in_ready_q;

   // State register and datapath registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         shift_q     <= '0;
         cnt_q       <= '0;
         gap_q       <= '0;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         shift_q     <= shift_d;
         cnt_q       <= cnt_d;
         gap_q       <= gap_d;
      end
   end

   // Next-state, datapath update and next-cycle output values.
   always_comb begin
      state_d        = state_q;
      hold_d         = hold_q;
      hold_full_d    = hold_full_q;
      shift_d        = shift_q;
      cnt_d          = cnt_q;
      gap_d          = gap_q;
      load_c         = 1'b0;
      in_ready_d     = 1'b0;
      serial_out_d   = 1'b0;
      serial_valid_d = 1'b0;
      frame_start_d  = 1'b0;
      frame_end_d    = 1'b0;
      busy_d         = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (hold_full_q) begin
               load_c  = 1'b1;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (cnt_q == LAST_BIT) begin
               if (GAP != 0) begin
                  gap_d   = '0;
                  state_d = ST_GAP;
               end else if (hold_full_q) begin
                  load_c  = 1'b1;
                  state_d = ST_SHIFT;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               cnt_d   = cnt_q + CNT_W'(1);
               shift_d = shift_once(shift_q);
            end
         end
         ST_GAP: begin
            if (gap_q == LAST_GAP) begin
               if (hold_full_q) begin
                  load_c  = 1'b1;
                  state_d = ST_SHIFT;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               gap_d = gap_q + GAP_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Move the held word into the shifter; frees the holding register.
      if (load_c) begin
         shift_d     = hold_q;
         cnt_d       = '0;
         hold_full_d = 1'b0;
      end

      // Accept only into an empty holding register, so never overlaps a load.
      if (accept_c) begin
         hold_d      = bus.in_data;
         hold_full_d = 1'b1;
      end

      in_ready_d = ~hold_full_d;
      busy_d     = (state_d != ST_IDLE) | hold_full_d;
      if (state_d == ST_SHIFT) begin
         serial_valid_d = 1'b1;
         serial_out_d   = head_bit(shift_d);
         frame_start_d  = (cnt_d == '0);
         frame_end_d    = (cnt_d == LAST_BIT);
      end
   end

   // Registered outputs, all cleared by reset.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         in_ready_q     <= 1'b0;
         serial_out_q   <= 1'b0;
         serial_valid_q <= 1'b0;
         frame_start_q  <= 1'b0;
         frame_end_q    <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         in_ready_q     <= in_ready_d;
         serial_out_q   <= serial_out_d;
         serial_valid_q <= serial_valid_d;
         frame_start_q  <= frame_start_d;
         frame_end_q    <= frame_end_d;
         busy_q         <= busy_d;
      end
   end

   assign bus.in_ready     = in_ready_q;
   assign bus.serial_out   = serial_out_q;
   assign bus.serial_valid = serial_valid_q;
   assign bus.frame_start  = frame_start_q;
   assign bus.frame_end    = frame_end_q;
   assign bus.busy         = busy_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: three instances (MSB-first, LSB-first, GAP=2)
// checked against a per-instance queue of expected serial bits.
module tb_piso_serializer;

   typedef struct packed {
      logic b;
      logic fs;
      logic fe;
   } exp_t;

   typedef struct {
      logic [3:0] word;
      logic [3:0] seq_msb;   // bits in send order, first-sent in bit 3
      logic [3:0] seq_lsb;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n [3];
   logic       vld   [3];
   logic [3:0] dat   [3];
   logic       rdy   [3];
   logic       so    [3];
   logic       sv    [3];
   logic       fs    [3];
   logic       fe    [3];
   logic       bsy   [3];

   int total = 0;
   int bad   = 0;

   exp_t sb0[$];
   exp_t sb1[$];
   exp_t sb2[$];
   exp_t mon_e;

   always #5 clk = ~clk;

   piso_serializer_if #(.WIDTH(4)) bus0 ();
   piso_serializer_if #(.WIDTH(4)) bus1 ();
   piso_serializer_if #(.WIDTH(4)) bus2 ();

   assign bus0.in_valid = vld[0];
   assign bus0.in_data  = dat[0];
   assign bus1.in_valid = vld[1];
   assign bus1.in_data  = dat[1];
   assign bus2.in_valid = vld[2];
   assign bus2.in_data  = dat[2];

   assign rdy[0] = bus0.in_ready;
   assign so[0]  = bus0.serial_out;
   assign sv[0]  = bus0.serial_valid;
   assign fs[0]  = bus0.frame_start;
   assign fe[0]  = bus0.frame_end;
   assign bsy[0] = bus0.busy;
   assign rdy[1] = bus1.in_ready;
   assign so[1]  = bus1.serial_out;
   assign sv[1]  = bus1.serial_valid;
   assign fs[1]  = bus1.frame_start;
   assign fe[1]  = bus1.frame_end;
   assign bsy[1] = bus1.busy;
   assign rdy[2] = bus2.in_ready;
   assign so[2]  = bus2.serial_out;
   assign sv[2]  = bus2.serial_valid;
   assign fs[2]  = bus2.frame_start;
   assign fe[2]  = bus2.frame_end;
   assign bsy[2] = bus2.busy;

   piso_serializer #(.WIDTH(4), .MSB_FIRST(1), .GAP(0)) dut0 (
      .clock (clk),
      .reset (rst_n[0]),
      .bus   (bus0)
   );
   piso_serializer #(.WIDTH(4), .MSB_FIRST(0), .GAP(0)) dut1 (
      .clock (clk),
      .reset (rst_n[1]),
      .bus   (bus1)
   );
   piso_serializer #(.WIDTH(4), .MSB_FIRST(1), .GAP(2)) dut2 (
      .clock (clk),
      .reset (rst_n[2]),
      .bus   (bus2)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
      end
   endtask

   function automatic int sb_size(input int k);
      case (k)
         0:       return sb0.size();
         1:       return sb1.size();
         default: return sb2.size();
      endcase
   endfunction

   function automatic exp_t sb_pop(input int k);
      case (k)
         0:       return sb0.pop_front();
         1:       return sb1.pop_front();
         default: return sb2.pop_front();
      endcase
   endfunction

   // Expected bits of one word, seq holds them in send order (bit 3 first).
   function automatic void sb_push(input int k, input logic [3:0] seq);
      exp_t e;
      for (int i = 0; i < 4; i++) begin
         e.b  = seq[3-i];
         e.fs = (i == 0);
         e.fe = (i == 3);
         case (k)
            0:       sb0.push_back(e);
            1:       sb1.push_back(e);
            default: sb2.push_back(e);
         endcase
      end
   endfunction

   // Scoreboard monitor: every valid bit must match the next expected entry.
   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (rst_n[k]) begin
            if (sv[k]) begin
               chk($sformatf("d%0d bit_expected", k), 32'(sb_size(k) != 0), 1);
               if (sb_size(k) != 0) begin
                  mon_e = sb_pop(k);
                  chk($sformatf("d%0d serial_out", k), 32'(so[k]), 32'(mon_e.b));
                  chk($sformatf("d%0d frame_start", k), 32'(fs[k]), 32'(mon_e.fs));
                  chk($sformatf("d%0d frame_end", k), 32'(fe[k]), 32'(mon_e.fe));
               end
            end else begin
               chk($sformatf("d%0d idle_serial_out", k), 32'(so[k]), 0);
               chk($sformatf("d%0d idle_frame_flags", k), 32'(fs[k] | fe[k]), 0);
            end
         end
      end
   end

   // Offer a word, wait for acceptance, then queue its expected bits.
   task automatic send(input int k, input logic [3:0] w, input logic [3:0] seq);
      int n;
      vld[k] = 1'b1;
      dat[k] = w;
      n = 0;
      while (!rdy[k] && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk($sformatf("d%0d accept_wait", k), 32'(rdy[k]), 1);
      if (rdy[k]) begin
         @(posedge clk);
         sb_push(k, seq);
         #1;
         chk($sformatf("d%0d ready_after_accept", k), 32'(rdy[k]), 0);
         chk($sformatf("d%0d busy_after_accept", k), 32'(bsy[k]), 1);
      end
      vld[k] = 1'b0;
   endtask

   // Wait until every instance has emitted all queued bits and gone idle.
   task automatic drain();
      int  n;
      logic pend;
      n = 0;
      pend = 1'b1;
      while (pend && n < 300) begin
         @(negedge clk);
         pend = (sb0.size() != 0) || (sb1.size() != 0) || (sb2.size() != 0) ||
                bsy[0] || bsy[1] || bsy[2];
         n++;
      end
      chk("drain_pending", 32'(pend), 0);
      @(posedge clk);
      #1;
   endtask

   // Wait (bounded) for the first valid bit, then check a valid pattern per cycle.
   task automatic check_pattern(input int k, input string name, input logic pat [], input int len);
      int n;
      n = 0;
      @(negedge clk);
      while (!sv[k] && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_start"}, 32'(sv[k]), 1);
      for (int j = 0; j < len; j++) begin
         chk($sformatf("%s_valid[%0d]", name, j), 32'(sv[k]), 32'(pat[j]));
         @(negedge clk);
      end
   endtask

   vec_t tbl [8];
   logic pat_a [];
   logic pat_c [];

   initial begin
      tbl[0] = '{word: 4'b1011, seq_msb: 4'b1011, seq_lsb: 4'b1101};
      tbl[1] = '{word: 4'b0001, seq_msb: 4'b0001, seq_lsb: 4'b1000};
      tbl[2] = '{word: 4'b1100, seq_msb: 4'b1100, seq_lsb: 4'b0011};
      tbl[3] = '{word: 4'b0110, seq_msb: 4'b0110, seq_lsb: 4'b0110};
      tbl[4] = '{word: 4'b1010, seq_msb: 4'b1010, seq_lsb: 4'b0101};
      tbl[5] = '{word: 4'b0101, seq_msb: 4'b0101, seq_lsb: 4'b1010};
      tbl[6] = '{word: 4'b1111, seq_msb: 4'b1111, seq_lsb: 4'b1111};
      tbl[7] = '{word: 4'b1000, seq_msb: 4'b1000, seq_lsb: 4'b0001};

      pat_a = new[12];
      for (int j = 0; j < 12; j++) pat_a[j] = 1'b1;
      pat_c = new[11];
      pat_c = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

      for (int k = 0; k < 3; k++) begin
         rst_n[k] = 1'b0;
         vld[k]   = 1'b0;
         dat[k]   = 4'h0;
      end

      // Reset values.
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("d%0d rst_in_ready", k), 32'(rdy[k]), 0);
         chk($sformatf("d%0d rst_serial_out", k), 32'(so[k]), 0);
         chk($sformatf("d%0d rst_serial_valid", k), 32'(sv[k]), 0);
         chk($sformatf("d%0d rst_frame", k), 32'({fs[k], fe[k]}), 0);
         chk($sformatf("d%0d rst_busy", k), 32'(bsy[k]), 0);
         rst_n[k] = 1'b1;
      end
      #1;
      chk("rel_ready_before_edge", 32'(rdy[0]), 0);
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) chk($sformatf("d%0d rel_ready", k), 32'(rdy[k]), 1);

      // Table of words through all three configurations.
      for (int i = 0; i < 8; i++) begin
         send(0, tbl[i].word, tbl[i].seq_msb);
         send(1, tbl[i].word, tbl[i].seq_lsb);
         send(2, tbl[i].word, tbl[i].seq_msb);
      end
      drain();

      // Two-edge latency and a single framed word: 0 then 4 valid then 0.
      send(0, 4'b1011, 4'b1011);
      for (int j = 0; j < 6; j++) begin
         @(negedge clk);
         chk($sformatf("latency_valid[%0d]", j), 32'(sv[0]), 32'((j >= 1) && (j <= 4)));
      end
      drain();

      // Back-to-back words with GAP=0: 12 contiguous valid bits.
      fork
         begin
            send(0, 4'hA, 4'hA);
            send(0, 4'h5, 4'h5);
            send(0, 4'hF, 4'hF);
         end
         begin
            pat_a = new[13](pat_a);
            pat_a[12] = 1'b0;
            check_pattern(0, "contig", pat_a, 13);
         end
      join
      drain();

      // GAP=2: 1001, two idle cycles, 0110.
      fork
         begin
            send(2, 4'h9, 4'h9);
            send(2, 4'h6, 4'h6);
         end
         check_pattern(2, "gap", pat_c, 11);
      join
      drain();

      // Reset on the second bit of 4'hC while 4'h3 is held.
      send(0, 4'hC, 4'hC);
      send(0, 4'h3, 4'h3);
      chk("mid_second_bit_valid", 32'(sv[0]), 1);
      chk("mid_second_bit_value", 32'(so[0]), 1);
      chk("mid_second_bit_start", 32'(fs[0]), 0);
      rst_n[0] = 1'b0;
      #1;
      chk("async_in_ready", 32'(rdy[0]), 0);
      chk("async_serial_out", 32'(so[0]), 0);
      chk("async_serial_valid", 32'(sv[0]), 0);
      chk("async_frame", 32'({fs[0], fe[0]}), 0);
      chk("async_busy", 32'(bsy[0]), 0);
      sb0.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n[0] = 1'b1;
      #1;
      chk("rerel_ready_before_edge", 32'(rdy[0]), 0);
      @(posedge clk);
      #1;
      chk("rerel_ready", 32'(rdy[0]), 1);
      for (int j = 0; j < 8; j++) begin
         @(negedge clk);
         chk($sformatf("no_stale_bits[%0d]", j), 32'(sv[0]), 0);
      end
      @(posedge clk);
      #1;

      // in_data toggling while in_ready is low: only the accepted word goes out.
      send(0, 4'h6, 4'h6);
      send(0, 4'h9, 4'h9);
      begin
         int n;
         vld[0] = 1'b1;
         n = 0;
         while (!rdy[0] && n < 20) begin
            dat[0] = n[0] ? 4'h3 : 4'hC;
            @(posedge clk);
            #1;
            n++;
         end
         chk("stall_cycles_min3", 32'(n >= 3), 1);
         dat[0] = n[0] ? 4'h3 : 4'hC;
         @(posedge clk);
         sb_push(0, dat[0]);
         #1;
         vld[0] = 1'b0;
         chk("stall_ready_after_accept", 32'(rdy[0]), 0);
         for (int j = 0; j < 6; j++) begin
            dat[0] = dat[0] ^ 4'hF;
            @(posedge clk);
            #1;
         end
      end
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
